cpu_data_in_latch: RTL and testbench

Inbound half of the 6801 core's external data bus. It captures bytes read from memory/peripherals into the 16-bit memory-data register `md`, and applies the register's non-bus updates (ALU load, left shift). It also generates a wait-state stall when the bus has not yet presented valid data. `md` feeds the outbound bus mux and the ALU operand path.

---
 rtl/cpu_data_in_latch.sv | 111 +++++++++++
 tb/tb_cpu_data_in_latch.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/cpu_data_in_latch.sv
// cpu_data_in_latch
// Inbound half of the 6801 core's external data bus. Captures bytes read from
// memory/peripherals into the 16-bit memory-data register md. Also applies the
// register's non-bus updates (ALU load, left shift). Raises a combinational
// stall while a fetch is waiting on the bus.
//
// Parameters:
//   WAIT_LIMIT   maximum consecutive wait cycles before a fetch is forced to
//                complete with 8'hFF and flagged as a bus error (>= 1)
// Ports:
//   clk          core clock, all state updates on the rising edge
//   rst          synchronous active-high reset
//   data_in      byte read from the external bus
//   data_valid   bus ready, data_in is valid this cycle
//   alu_out      ALU result used by the load_alu op
//   md_ctrl      op select: 000 latch, 001 load_alu, 010 fetch_first,
//                011 fetch_next, 100 shiftl, 101-111 hold
//   md           memory-data register
//   stall        combinational, sequencer must freeze this cycle
//   byte_strobe  registered one-cycle pulse the cycle after a fetch completes
//   timeout      sticky bus-error flag, cleared only by rst

module cpu_data_in_latch #(
    parameter int WAIT_LIMIT = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  data_in,
    input  logic        data_valid,
    input  logic [15:0] alu_out,
    input  logic [2:0]  md_ctrl,
    output logic [15:0] md,
    output logic        stall,
    output logic        byte_strobe,
    output logic        timeout
);

    typedef enum logic [2:0] {
        OP_LATCH       = 3'b000,
        OP_LOAD_ALU    = 3'b001,
        OP_FETCH_FIRST = 3'b010,
        OP_FETCH_NEXT  = 3'b011,
        OP_SHIFTL      = 3'b100
    } md_op_e;

    localparam int             WCW        = $clog2(WAIT_LIMIT + 1);
    localparam logic [WCW-1:0] WCNT_LIMIT = WCW'(WAIT_LIMIT);

    logic [WCW-1:0] wcnt;
    logic           fetch;
    logic           at_limit;
    logic           complete;
    logic           forced;
    logic [7:0]     cap_byte;

    assign fetch    = (md_ctrl == OP_FETCH_FIRST) || (md_ctrl == OP_FETCH_NEXT);
    assign at_limit = (wcnt == WCNT_LIMIT);
    assign complete = fetch && (data_valid || at_limit);
    assign forced   = fetch && !data_valid && at_limit;
    // A forced completion reads back as an undriven (pulled-up) bus.
    assign cap_byte = data_valid ? data_in : 8'hFF;

    // Stall releases in the limit cycle so the forced completion can proceed.
    assign stall = !rst && fetch && !data_valid && !at_limit;

    always_ff @(posedge clk) begin
        if (rst) begin
            md          <= 16'h0000;
            wcnt        <= '0;
            byte_strobe <= 1'b0;
            timeout     <= 1'b0;
        end else begin
            // Counter only survives while a fetch keeps waiting; switching
            // between the two fetch ops keeps the count running.
            if (fetch && !complete) begin
                wcnt <= wcnt + WCW'(1);
            end else begin
                wcnt <= '0;
            end

            byte_strobe <= complete;

            if (forced) begin
                timeout <= 1'b1;
            end

            case (md_ctrl)
                OP_LOAD_ALU: begin
                    md <= alu_out;
                end
                OP_FETCH_FIRST: begin
                    if (complete) begin
                        md <= {8'h00, cap_byte};
                    end
                end
                OP_FETCH_NEXT: begin
                    if (complete) begin
                        md <= {md[7:0], cap_byte};
                    end
                end
                OP_SHIFTL: begin
                    md <= {md[14:0], 1'b0};
                end
                default: begin
                    md <= md;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_data_in_latch.sv
// tb_cpu_data_in_latch
// Drives one stimulus stream into two instances of cpu_data_in_latch, one with
// the default WAIT_LIMIT of 15 and one with WAIT_LIMIT of 4, and compares both
// against a cycle-level reference model kept here. Directed steps walk through
// the documented scenarios, then a randomized phase mixes all ops, bus waits
// and occasional resets.

module tb_cpu_data_in_latch;

    logic        clk;
    logic        rst;
    logic [7:0]  data_in;
    logic        data_valid;
    logic [15:0] alu_out;
    logic [2:0]  md_ctrl;

    logic [15:0] md_o [2];
    logic [1:0]  stall_o;
    logic [1:0]  bs_o;
    logic [1:0]  to_o;

    int checks_total;
    int checks_passed;

    // Reference model state, index 0 = WAIT_LIMIT 15, index 1 = WAIT_LIMIT 4
    int          m_lim [2];
    logic [15:0] m_md  [2];
    int          m_wait[2];
    bit          m_to  [2];
    bit          m_bs  [2];

    cpu_data_in_latch #(.WAIT_LIMIT(15)) dut15 (
        .clk         (clk),
        .rst         (rst),
        .data_in     (data_in),
        .data_valid  (data_valid),
        .alu_out     (alu_out),
        .md_ctrl     (md_ctrl),
        .md          (md_o[0]),
        .stall       (stall_o[0]),
        .byte_strobe (bs_o[0]),
        .timeout     (to_o[0])
    );

    cpu_data_in_latch #(.WAIT_LIMIT(4)) dut4 (
        .clk         (clk),
        .rst         (rst),
        .data_in     (data_in),
        .data_valid  (data_valid),
        .alu_out     (alu_out),
        .md_ctrl     (md_ctrl),
        .md          (md_o[1]),
        .stall       (stall_o[1]),
        .byte_strobe (bs_o[1]),
        .timeout     (to_o[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks_total++;
        assert (obs === exp) begin
            checks_passed++;
        end else begin
            $error("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int wcnt_of(input int i);
        return (i == 0) ? 32'(dut15.wcnt) : 32'(dut4.wcnt);
    endfunction

    // One clock cycle: drive inputs on the falling edge, check the
    // combinational stall, then advance the model across the rising edge and
    // check all registered state.
    task automatic applyStimulus(input logic [2:0] ctrl, input logic [7:0] din,
                                 input logic dv, input logic [15:0] alu, input logic rst_i);
        bit   is_fetch;
        bit   done;
        logic [7:0] b;
        @(negedge clk);
        md_ctrl    = ctrl;
        data_in    = din;
        data_valid = dv;
        alu_out    = alu;
        rst        = rst_i;
        #1;
        is_fetch = (ctrl == 3'd2) || (ctrl == 3'd3);
        for (int i = 0; i < 2; i++) begin
            checkOutput($sformatf("stall[lim%0d]", m_lim[i]), 32'(stall_o[i]),
                        32'(!rst_i && is_fetch && !dv && (m_wait[i] < m_lim[i])));
        end
        @(posedge clk);
        for (int i = 0; i < 2; i++) begin
            if (rst_i) begin
                m_md[i] = 16'h0000; m_wait[i] = 0; m_to[i] = 0; m_bs[i] = 0;
            end else begin
                done = is_fetch && (dv || m_wait[i] == m_lim[i]);
                b    = dv ? din : 8'hFF;
                if (is_fetch && !dv && m_wait[i] == m_lim[i]) m_to[i] = 1;
                if (ctrl == 3'd1) m_md[i] = alu;
                else if (ctrl == 3'd4) m_md[i] = 16'((32'(m_md[i]) * 2) % 65536);
                else if (done && ctrl == 3'd2) m_md[i] = {8'h00, b};
                else if (done && ctrl == 3'd3) m_md[i] = 16'((32'(m_md[i]) % 256) * 256 + 32'(b));
                m_wait[i] = (is_fetch && !done) ? m_wait[i] + 1 : 0;
                m_bs[i]   = done;
            end
        end
        #1;
        for (int i = 0; i < 2; i++) begin
            checkOutput($sformatf("md[lim%0d]", m_lim[i]), 32'(md_o[i]), 32'(m_md[i]));
            checkOutput($sformatf("byte_strobe[lim%0d]", m_lim[i]), 32'(bs_o[i]), 32'(m_bs[i]));
            checkOutput($sformatf("timeout[lim%0d]", m_lim[i]), 32'(to_o[i]), 32'(m_to[i]));
            checkOutput($sformatf("wcnt[lim%0d]", m_lim[i]), 32'(wcnt_of(i)), 32'(m_wait[i]));
        end
    endtask

    initial begin
        logic [2:0] op;
        int         n;
        checks_total  = 0;
        checks_passed = 0;
        m_lim[0] = 15; m_lim[1] = 4;
        for (int i = 0; i < 2; i++) begin
            m_md[i] = 16'h0000; m_wait[i] = 0; m_to[i] = 0; m_bs[i] = 0;
        end
        rst = 1'b1; md_ctrl = 3'd2; data_in = 8'h00; data_valid = 1'b0; alu_out = 16'h0000;

        $display("[TB] reset with pending fetch");
        applyStimulus(3'd2, 8'h00, 1'b0, 16'h0000, 1'b1);
        applyStimulus(3'd2, 8'h00, 1'b0, 16'h0000, 1'b1);
        checkOutput("reset md", 32'(md_o[0]), 32'h0000);
        checkOutput("reset timeout", 32'(to_o[0]), 32'h0);

        $display("[TB] zero-wait 16-bit fetch");
        applyStimulus(3'd2, 8'hA5, 1'b1, 16'h0000, 1'b0);
        checkOutput("fetch_first md", 32'(md_o[0]), 32'h00A5);
        checkOutput("fetch_first strobe", 32'(bs_o[0]), 32'h1);
        applyStimulus(3'd3, 8'h3C, 1'b1, 16'h0000, 1'b0);
        checkOutput("fetch_next md", 32'(md_o[0]), 32'hA53C);
        checkOutput("fetch_next strobe", 32'(bs_o[0]), 32'h1);

        $display("[TB] non-bus ops");
        applyStimulus(3'd4, 8'h00, 1'b0, 16'h0000, 1'b0);
        checkOutput("shiftl md", 32'(md_o[0]), 32'h4A78);
        applyStimulus(3'd1, 8'h00, 1'b0, 16'h1234, 1'b0);
        checkOutput("load_alu md", 32'(md_o[0]), 32'h1234);
        applyStimulus(3'd0, 8'hFF, 1'b1, 16'h0000, 1'b0);
        checkOutput("latch md", 32'(md_o[0]), 32'h1234);
        checkOutput("latch strobe", 32'(bs_o[0]), 32'h0);

        $display("[TB] three wait states");
        for (int k = 0; k < 3; k++) applyStimulus(3'd2, 8'h00, 1'b0, 16'h0000, 1'b0);
        applyStimulus(3'd2, 8'h7E, 1'b1, 16'h0000, 1'b0);
        checkOutput("wait md", 32'(md_o[0]), 32'h007E);
        checkOutput("wait timeout", 32'(to_o[0]), 32'h0);

        $display("[TB] bus timeout");
        applyStimulus(3'd1, 8'h00, 1'b0, 16'h0012, 1'b0);
        for (int k = 0; k < 5; k++) applyStimulus(3'd3, 8'h00, 1'b0, 16'h0000, 1'b0);
        checkOutput("timeout md lim4", 32'(md_o[1]), 32'h12FF);
        checkOutput("timeout flag lim4", 32'(to_o[1]), 32'h1);
        checkOutput("no timeout lim15", 32'(to_o[0]), 32'h0);
        applyStimulus(3'd2, 8'h55, 1'b1, 16'h0000, 1'b0);
        checkOutput("sticky timeout lim4", 32'(to_o[1]), 32'h1);
        checkOutput("post-timeout md lim4", 32'(md_o[1]), 32'h0055);

        $display("[TB] abandon and reset mid-wait");
        applyStimulus(3'd2, 8'h00, 1'b0, 16'h0000, 1'b0);
        applyStimulus(3'd2, 8'h00, 1'b0, 16'h0000, 1'b0);
        applyStimulus(3'd1, 8'h00, 1'b0, 16'hBEEF, 1'b0);
        checkOutput("abandon md", 32'(md_o[0]), 32'hBEEF);
        checkOutput("abandon wcnt", 32'(wcnt_of(0)), 32'h0);
        applyStimulus(3'd2, 8'h00, 1'b0, 16'h0000, 1'b0);
        applyStimulus(3'd2, 8'h00, 1'b0, 16'h0000, 1'b0);
        applyStimulus(3'd2, 8'h00, 1'b0, 16'h0000, 1'b1);
        checkOutput("mid-wait reset md", 32'(md_o[1]), 32'h0000);
        checkOutput("mid-wait reset timeout", 32'(to_o[1]), 32'h0);

        $display("[TB] randomized traffic");
        for (int k = 0; k < 300; k++) begin
            if ($urandom_range(0, 9) == 0) begin
                // Long bus hold to exercise the forced-completion path
                n = $urandom_range(3, 17);
                for (int j = 0; j < n; j++) begin
                    op = 3'(2 + $urandom_range(0, 1));
                    applyStimulus(op, 8'($urandom), 1'b0, 16'($urandom), 1'b0);
                end
            end else begin
                op = 3'($urandom_range(0, 7));
                applyStimulus(op, 8'($urandom), ($urandom_range(0, 2) != 0),
                              16'($urandom), ($urandom_range(0, 59) == 0));
            end
        end

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
